// File: rtl/vc_link_arbiter_pkg.sv
// rtl/vc_link_arbiter_pkg.sv - shared types and helpers for the credit link arbiter
package vc_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int MAX_REQ = 8;
    localparam int GRANT_W = $clog2(MAX_REQ);

    typedef logic [GRANT_W-1:0] grant_idx_t;

    // Next round-robin start position, wrapping at num_req.
    function automatic grant_idx_t rr_next(input grant_idx_t ptr, input int unsigned num_req);
        if (32'(ptr) + 32'd1 >= num_req) begin
            return '0;
        end
        return ptr + grant_idx_t'(1);
    endfunction

endpackage

// File: rtl/vc_link_arbiter_if.sv
// rtl/vc_link_arbiter_if.sv - requester handshake and credit link bundle
interface vc_link_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           link_valid;
    logic [DATA_W-1:0]              link_data;
    logic                           link_credit;

    modport master (
        output req_valid, req_data, req_last, link_credit,
        input  req_ready, link_valid, link_data
    );

    modport slave (
        input  req_valid, req_data, req_last, link_credit,
        output req_ready, link_valid, link_data
    );
endinterface

// File: rtl/vc_link_arbiter_rr_pick.sv
// rtl/vc_link_arbiter_rr_pick.sv - first set request at or after ptr, with wrap
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);
    int idx;

    // Scan from the farthest offset down so the closest request to ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx[W-1:0]]) begin
                gnt_idx = idx[W-1:0];
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vc_link_arbiter.sv
// rtl/vc_link_arbiter.sv - packet-locked round-robin arbiter onto a credit-flow-controlled link
module vc_link_arbiter
    import vc_arb_pkg::*;
#(
    parameter int   NUM_REQ = 4,
    parameter int   DATA_W  = 8,
    parameter int   CREDITS = 7,
    localparam int  CNT_W   = $clog2(CREDITS + 1),
    localparam int  GNT_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    vc_link_arbiter_if.slave link,
    output logic [CNT_W-1:0] credit_cnt,
    output logic [GNT_W-1:0] grant_id,
    output logic             busy,
    output logic             err_credit_ovf
);
    arb_state_t       state, state_nxt;
    logic [GNT_W-1:0] rr_ptr, rr_ptr_nxt, grant_nxt, pick_idx;
    logic             pick_any, has_credit, accept, accept_last;
    logic [DATA_W-1:0] beat_data;

    rr_priority_pick #(.N(NUM_REQ), .W(GNT_W)) u_pick (
        .req     (link.req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign busy        = (state == LOCK);
    assign has_credit  = (credit_cnt != '0);
    assign accept      = busy & has_credit & link.req_valid[grant_id];
    assign accept_last = accept & link.req_last[grant_id];
    assign beat_data   = link.req_data[grant_id];

    // Ready depends only on lock owner and credits, never on valid.
    always_comb begin
        link.req_ready = '0;
        if (busy && has_credit) begin
            link.req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = LOCK;
                    grant_nxt = pick_idx;
                end
            end
            LOCK: begin
                if (accept_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = GNT_W'(rr_next(grant_idx_t'(grant_id), NUM_REQ));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // A simultaneous accept and returned credit cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt     <= CNT_W'(CREDITS);
            err_credit_ovf <= 1'b0;
        end else if (accept && !link.link_credit) begin
            credit_cnt <= credit_cnt - CNT_W'(1);
        end else if (!accept && link.link_credit) begin
            if (credit_cnt == CNT_W'(CREDITS)) begin
                err_credit_ovf <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link.link_valid <= 1'b0;
            link.link_data  <= '0;
        end else begin
            link.link_valid <= accept;
            if (accept) begin
                link.link_data <= beat_data;
            end
        end
    end
endmodule

// File: tb/tb_vc_link_arbiter.sv
// tb/tb_vc_link_arbiter.sv - self-checking bench for vc_link_arbiter
module tb_vc_link_arbiter;
    import vc_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int C  = 7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] credit_cnt;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_credit_ovf;

    always #5 clk = ~clk;

    vc_link_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    vc_link_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CREDITS(C)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .link           (bus),
        .credit_cnt     (credit_cnt),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_credit_ovf (err_credit_ovf)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: packet owner, next start position, credits, link register
    int m_lock, m_owner, m_ptr, m_cred, m_lv, m_ld, m_err;
    int acc_id;
    int last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_owner = 0; m_ptr = 0; m_cred = C;
        m_lv = 0; m_ld = 0; m_err = 0;
    endtask

    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_last    = '0;
        bus.req_data    = '0;
        bus.link_credit = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_credit_cnt", 32'(credit_cnt), C);
        chk("rst_link_valid", 32'(bus.link_valid), 0);
        chk("rst_link_data",  32'(bus.link_data), 0);
        chk("rst_busy",       32'(busy), 0);
        chk("rst_err",        32'(err_credit_ovf), 0);
        chk("rst_grant_id",   32'(grant_id), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock: inputs already driven just after a negedge; returns at the next negedge.
    task automatic cycle();
        int acc, lst, cr, d, found;
        logic [N-1:0] v;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("req_ready", 32'(bus.req_ready[i]), (m_lock != 0 && m_owner == i && m_cred > 0) ? 1 : 0);
        end
        v   = bus.req_valid;
        cr  = bus.link_credit;
        acc = (m_lock != 0 && m_cred > 0 && v[m_owner]) ? 1 : 0;
        lst = (acc != 0 && bus.req_last[m_owner]) ? 1 : 0;
        d   = 32'(bus.req_data[m_owner]);
        acc_id   = (acc != 0) ? m_owner : -1;
        last_acc = lst;
        @(posedge clk);
        if (m_lock == 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (found == 0 && v[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_lock  = 1;
                    found   = 1;
                end
            end
        end else if (lst != 0) begin
            m_lock = 0;
            m_ptr  = (m_owner + 1) % N;
        end
        if (acc != 0 && cr == 0) m_cred--;
        else if (acc == 0 && cr != 0) begin
            if (m_cred == C) m_err = 1;
            else m_cred++;
        end
        m_lv = acc;
        if (acc != 0) m_ld = d;
        @(negedge clk);
        chk("link_valid", 32'(bus.link_valid), m_lv);
        chk("link_data",  32'(bus.link_data), m_ld);
        chk("credit_cnt", 32'(credit_cnt), m_cred);
        chk("busy",       32'(busy), m_lock);
        chk("err_ovf",    32'(err_credit_ovf), m_err);
        if (m_lock != 0) chk("grant_id", 32'(grant_id), m_owner);
    endtask

    initial begin
        int pk[N];
        int bt[N];
        int nacc, ncyc, prev_busy, rem;
        int exp_order[4];
        int dut_order[$];

        clear_inputs();
        @(negedge clk);
        do_reset();

        // Single 3-beat packet from requester 1
        bus.req_valid[1] = 1'b1; bus.req_data[1] = 8'hA1;
        cycle();
        chk("sp_busy", 32'(busy), 1);
        chk("sp_grant", 32'(grant_id), 1);
        cycle();
        chk("sp_beat1", 32'(bus.link_data), 32'hA1);
        bus.req_data[1] = 8'hA2;
        cycle();
        bus.req_data[1] = 8'hA3; bus.req_last[1] = 1'b1;
        cycle();
        chk("sp_beat3", 32'(bus.link_data), 32'hA3);
        chk("sp_credit", 32'(credit_cnt), 4);
        chk("sp_idle", 32'(busy), 0);
        clear_inputs();
        cycle();

        // Credit starvation: 9-beat packet, no credits returned
        do_reset();
        nacc = 0;
        bus.req_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.req_data[0] = 8'(nacc);
            cycle();
            if (acc_id == 0) nacc++;
        end
        chk("st_beats", nacc, 7);
        chk("st_credit", 32'(credit_cnt), 0);
        chk("st_ready0", 32'(bus.req_ready[0]), 0);
        chk("st_busy", 32'(busy), 1);
        bus.link_credit = 1'b1;
        cycle();
        bus.link_credit = 1'b0;
        chk("st_cred_back", 32'(credit_cnt), 1);
        chk("st_no_beat", 32'(bus.link_valid), 0);
        bus.req_data[0] = 8'h77;
        cycle();
        chk("st_one_beat", 32'(bus.link_valid), 1);
        chk("st_one_data", 32'(bus.link_data), 32'h77);
        cycle();
        chk("st_stall_again", 32'(bus.link_valid), 0);
        bus.req_last[0] = 1'b1; bus.link_credit = 1'b1;
        for (int c = 0; c < 6 && busy; c++) cycle();
        chk("st_release", 32'(busy), 0);
        clear_inputs();

        // Round-robin fairness with a credit back every cycle
        do_reset();
        pk = '{2, 0, 1, 1};
        bt = '{default: 0};
        exp_order = '{0, 2, 3, 0};
        ncyc = 0;
        rem = 4;
        for (int c = 0; c < 40 && rem > 0; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i] = (pk[i] > 0);
                bus.req_last[i]  = (bt[i] == 1);
                bus.req_data[i]  = 8'(16 * i + bt[i]);
            end
            bus.link_credit = 1'b1;
            prev_busy = 32'(busy);
            cycle();
            ncyc++;
            if (busy && prev_busy == 0) dut_order.push_back(32'(grant_id));
            if (acc_id >= 0) begin
                bt[acc_id]++;
                if (last_acc != 0) begin
                    bt[acc_id] = 0;
                    pk[acc_id]--;
                    rem--;
                end
            end
        end
        chk("rr_done", rem, 0);
        chk("rr_cycles", ncyc, 12);
        chk("rr_grants", dut_order.size(), 4);
        for (int k = 0; k < 4 && k < dut_order.size(); k++) chk("rr_order", dut_order[k], exp_order[k]);
        clear_inputs();

        // Accept and credit together hold the count at 3
        do_reset();
        bus.req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        chk("ac_start", 32'(credit_cnt), 3);
        bus.link_credit = 1'b1;
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            bus.req_data[1] = 8'(8'h30 + c);
            cycle();
            chk("ac_hold", 32'(credit_cnt), 3);
            if (bus.link_valid) nacc++;
        end
        chk("ac_beats", nacc, 5);
        bus.link_credit = 1'b0; bus.req_last[1] = 1'b1;
        cycle();
        clear_inputs();
        cycle();

        // Credit overflow while idle is sticky until reset
        do_reset();
        bus.link_credit = 1'b1;
        cycle();
        bus.link_credit = 1'b0;
        chk("ovf_count", 32'(credit_cnt), 7);
        chk("ovf_flag", 32'(err_credit_ovf), 1);
        for (int c = 0; c < 3; c++) cycle();
        chk("ovf_sticky", 32'(err_credit_ovf), 1);

        // Reset mid-packet, then a fresh grant searches from 0
        do_reset();
        bus.req_valid[2] = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        chk("mr_credit", 32'(credit_cnt), 5);
        do_reset();
        bus.req_valid[3] = 1'b1; bus.req_valid[1] = 1'b1;
        cycle();
        chk("mr_regrant", 32'(grant_id), 1);
        clear_inputs();

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i] = ($urandom_range(2) != 0);
                bus.req_last[i]  = ($urandom_range(2) == 0);
                bus.req_data[i]  = 8'($urandom);
            end
            bus.link_credit = ($urandom_range(1) == 1);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/vc_link_arbiter.md
# vc_link_arbiter

Round-robin scheduler that shares one valid/credit link among `NUM_REQ` valid/ready requesters and owns the sender-side credit counter. Each requester presents multi-beat packets delimited by `req_last`; the arbiter locks the link to one requester for a whole packet and issues beats only while credits remain. It sits between local producers and the pipelined link into a remote skid FIFO, whose depth sets the initial credit count.

## Interface
- `NUM_REQ`, default 4: number of requesters (2–8).
- `DATA_W`, default 8: beat payload width.
- `CREDITS`, default 7: receiver FIFO depth; initial and maximum credit count.
- `CNT_W`, default `$clog2(CREDITS+1)`: credit counter width; localparam.
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester beat valid.
- `req_data`, in, `NUM_REQ`×`DATA_W`: per-requester beat payload.
- `req_last`, in, `NUM_REQ`: final beat of the packet.
- `req_ready`, out, `NUM_REQ`: beat accepted when `valid & ready`.
- `link_valid`, out, 1: registered beat strobe to the link.
- `link_data`, out, `DATA_W`: registered beat payload.
- `link_credit`, in, 1: one-cycle pulse, one credit returned per pulse.
- `credit_cnt`, out, `CNT_W`: credits currently available.
- `grant_id`, out, `$clog2(NUM_REQ)`: locked requester; valid while `busy`.
- `busy`, out, 1: a packet is locked.
- `err_credit_ovf`, out, 1: sticky flag; credit returned while `credit_cnt == CREDITS`.

## Operation
- FSM states:
  - IDLE: no grant; all `req_ready` low.
  - LOCK: `req_ready[grant_id] = (credit_cnt != 0)`; all others low.
- IDLE → LOCK: when any `req_valid` is high, pick the first requester at or after `rr_ptr`, searching upward with wrap.
- LOCK → IDLE: on the cycle a beat with `req_last` is accepted. In the same edge, `rr_ptr <= grant_id + 1` modulo `NUM_REQ`.
- Beat accepted when `req_valid[g] & req_ready[g]`. On acceptance:
  - `link_valid <= 1`
  - `link_data <= req_data[g]`
  - otherwise `link_valid <= 0`; `link_data` holds its value.
- Credit counter update:
  - accept only: `credit_cnt - 1`.
  - credit only: `credit_cnt + 1`, saturating at `CREDITS`.
  - accept and credit together: unchanged.
  - credit while the counter is at `CREDITS` and no accept: counter stays at `CREDITS`; `err_credit_ovf` sets.
- `credit_cnt == 0` stalls the locked requester. The lock is held; other requesters stay blocked.
- `req_valid` dropping mid-packet is legal. The lock is held until `req_last` is accepted.
- Reset values:
  - state IDLE, `rr_ptr = 0`.
  - `credit_cnt = CREDITS`.
  - `link_valid = 0`, `link_data = 0`.
  - `grant_id = 0`, `busy = 0`, `err_credit_ovf = 0`.
- Reset asserted mid-packet: the packet is abandoned with no flush. Credits restore to `CREDITS`. The receiver must be reset in the same domain.

## Timing
- Request seen in IDLE at cycle t:
  - LOCK and `busy` at t+1.
  - First beat accepted at t+1 if credits are available.
  - First beat appears on `link_*` at t+2.
- Beat accepted at cycle t appears on `link_*` at t+1. Throughput is 1 beat/cycle while credits remain.
- There is one IDLE bubble cycle between packets. Minimum packet spacing is (beats + 1) cycles.
- A `link_credit` pulse at cycle t is visible in `credit_cnt` at t+1. It can enable acceptance at t+1.
- `req_ready` is combinational from state, `grant_id` and `credit_cnt` only. It never depends on `req_valid`.

## Structure
- Package `vc_arb_pkg`:
  - state enum `{IDLE, LOCK}`.
  - `grant_idx_t` typedef.
  - function `rr_next(ptr)`.
- Sub-module `rr_priority_pick`: combinational rotate-and-find-first over `NUM_REQ` bits. Inputs `req`, `ptr`; outputs `gnt_idx`, `gnt_any`.
- The top level holds the FSM, credit counter and link output register.

## Test plan
- Single packet, NUM_REQ=4, CREDITS=7: req1 sends 3 beats `0xA1`, `0xA2`, `0xA3`. Expected: LOCK at t+1; link beats at t+2..t+4; `credit_cnt` goes 7→4; `busy` drops after the last beat.
- Credit starvation: req0 sends 9 beats with no `link_credit`. Expected: 7 beats accepted, then `req_ready[0]` low with `credit_cnt = 0`. One credit pulse releases exactly one beat the next cycle.
- Round-robin fairness: req0, req2 and req3 each hold a 2-beat packet, with credits returned every cycle. Expected grant order 0, 2, 3, 0; one bubble cycle between packets.
- Simultaneous accept and credit for 5 cycles at `credit_cnt = 3`. Expected: counter stays at 3; 5 beats on the link.
- Credit overflow: `link_credit` pulse at `credit_cnt = 7` while idle. Expected: count stays 7; `err_credit_ovf = 1` until reset.
- Reset mid-packet: after 2 of 4 beats (`credit_cnt = 5`), pulse `reset_n` low. Expected: `credit_cnt = 7`, `link_valid = 0`, `busy = 0`, `rr_ptr = 0`; the next request is granted normally.
